// File: rtl/ct_spsram_256x59_acc_ctrl.sv
// Access controller in front of the 256x59 single-port SRAM: a read port and a
// posted, bit-masked write buffer share the one SRAM port, reads first.
module ct_spsram_256x59_acc_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 59,
    parameter int unsigned WBUF_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  rd_req_vld,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_req_rdy,
    output logic                  rd_data_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req_vld,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [DATA_WIDTH-1:0] wr_req_data,
    input  logic [DATA_WIDTH-1:0] wr_req_bmask,
    output logic                  wr_req_rdy,
    output logic                  wbuf_empty,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int unsigned PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_WIDTH-1:0] wb_addr_q [WBUF_DEPTH];
    logic [ADDR_WIDTH-1:0] wb_addr_d [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data_q [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data_d [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_mask_q [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_mask_d [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] wb_vld_q, wb_vld_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STV_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  rd_pend_q, rd_pend_d;

    logic hazard;
    logic wbuf_full;
    logic force_drain;
    logic rd_go;
    logic wr_drain;
    logic wr_push;

    // A read may not overtake a buffered write to the same address.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            if (wb_vld_q[i] && (wb_addr_q[i] == rd_req_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    assign wbuf_full   = (cnt_q == CNT_W'(WBUF_DEPTH));
    assign wbuf_empty  = (cnt_q == '0);
    assign force_drain = wbuf_full && (starve_cnt_q == STV_W'(STARVE_LIMIT));
    assign rd_req_rdy  = !hazard && !force_drain;
    assign rd_go       = rd_req_vld && rd_req_rdy;
    assign wr_drain    = !wbuf_empty && !rd_go;
    assign wr_req_rdy  = !wbuf_full || wr_drain;
    assign wr_push     = wr_req_vld && wr_req_rdy;

    assign rd_data_vld = rd_pend_q;
    assign rd_data     = rd_pend_q ? sram_q : '0;

    // Buffer bookkeeping; pop before push so a full buffer can recycle its head slot.
    always_comb begin
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        wb_mask_d    = wb_mask_q;
        wb_vld_d     = wb_vld_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q + CNT_W'(wr_push) - CNT_W'(wr_drain);
        starve_cnt_d = starve_cnt_q;
        rd_pend_d    = rd_go;

        if (wr_drain) begin
            wb_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d           = rd_ptr_q + PTR_W'(1);
        end
        if (wr_push) begin
            wb_addr_d[wr_ptr_q] = wr_req_addr;
            wb_data_d[wr_ptr_q] = wr_req_data;
            wb_mask_d[wr_ptr_q] = wr_req_bmask;
            wb_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end

        if (wr_drain) begin
            starve_cnt_d = '0;
        end else if (rd_go && wbuf_full && (starve_cnt_q != STV_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + STV_W'(1);
        end
    end

    // SRAM pins are sampled by the macro at the clock edge, so they are driven combinationally.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (rd_go) begin
            sram_cen = 1'b0;
            sram_a   = rd_req_addr;
        end else if (wr_drain) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_a    = wb_addr_q[rd_ptr_q];
            sram_d    = wb_data_q[rd_ptr_q];
            sram_wen  = ~wb_mask_q[rd_ptr_q];
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
                wb_mask_q[i] <= '0;
            end
            wb_vld_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            starve_cnt_q <= '0;
            rd_pend_q    <= 1'b0;
        end else begin
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            wb_mask_q    <= wb_mask_d;
            wb_vld_q     <= wb_vld_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_ct_spsram_256x59_acc_ctrl.sv
// Bench for ct_spsram_256x59_acc_ctrl: behavioural SRAM, directed stimulus,
// read-data scoreboard checked by an independent monitor.
module tb_ct_spsram_256x59_acc_ctrl;

    localparam int unsigned DW = 59;
    localparam logic [DW-1:0] ALL1 = 59'h7_FFFF_FFFF_FFFF_FF;
    localparam logic [DW-1:0] LOW0 = 59'h7_FFFF_FFFF_FFFF_00;
    localparam logic [DW-1:0] D5A  = 59'h1_2345_6789_ABCD_EF;
    localparam logic [DW-1:0] D5B  = 59'h6_0F0F_0F0F_0F0F_0F;
    localparam logic [DW-1:0] WA   = 59'h2_AAAA_AAAA_AAAA_AA;
    localparam logic [DW-1:0] WB   = 59'h5_5555_5555_5555_55;
    localparam logic [DW-1:0] W0   = 59'h0_1111_2222_3333_44;
    localparam logic [DW-1:0] W1   = 59'h0_5555_6666_7777_88;
    localparam logic [DW-1:0] W2   = 59'h0_9999_AAAA_BBBB_CC;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req_vld;
    logic [7:0]    rd_req_addr;
    logic          rd_req_rdy;
    logic          rd_data_vld;
    logic [DW-1:0] rd_data;
    logic          wr_req_vld;
    logic [7:0]    wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic [DW-1:0] wr_req_bmask;
    logic          wr_req_rdy;
    logic          wbuf_empty;
    logic [7:0]    sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    ct_spsram_256x59_acc_ctrl dut (
        .forever_cpuclk(clk),
        .cpurst_b      (rst_n),
        .rd_req_vld    (rd_req_vld),
        .rd_req_addr   (rd_req_addr),
        .rd_req_rdy    (rd_req_rdy),
        .rd_data_vld   (rd_data_vld),
        .rd_data       (rd_data),
        .wr_req_vld    (wr_req_vld),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .wr_req_bmask  (wr_req_bmask),
        .wr_req_rdy    (wr_req_rdy),
        .wbuf_empty    (wbuf_empty),
        .sram_a        (sram_a),
        .sram_cen      (sram_cen),
        .sram_gwen     (sram_gwen),
        .sram_wen      (sram_wen),
        .sram_d        (sram_d),
        .sram_q        (sram_q)
    );

    function automatic logic [DW-1:0] pat(input logic [7:0] a);
        return {3'b101, a, ~a, a, ~a, a, ~a, a};
    endfunction

    // Behavioural SRAM: preloaded on the first edge (inside reset), then bit-masked writes.
    logic [DW-1:0] mem [256];
    bit mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
            mem[8'h34]    <= ALL1;
            mem_init_done <= 1'b1;
        end else if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q      <= mem[sram_a];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rd_req_vld   = 1'b0;
        rd_req_addr  = '0;
        wr_req_vld   = 1'b0;
        wr_req_addr  = '0;
        wr_req_data  = '0;
        wr_req_bmask = '0;
    endtask

    task automatic wr_set(input logic [7:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        wr_req_vld   = 1'b1;
        wr_req_addr  = a;
        wr_req_data  = d;
        wr_req_bmask = m;
    endtask

    // Called at a negedge; holds the read until accepted, then checks the valid pulse.
    task automatic rd_wait(input logic [7:0] a, input logic [DW-1:0] e, input string name);
        bit ok;
        ok = 1'b0;
        rd_req_vld  = 1'b1;
        rd_req_addr = a;
        for (int n = 0; n < 8 && !ok; n++) begin
            #1;
            if (rd_req_rdy) begin
                exp_q.push_back(e);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        rd_req_vld = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: read not accepted, want accept within 8 cycles", name);
        end else begin
            #1;
            chk({name, "_vld"}, 64'(rd_data_vld), 64'(1));
        end
    endtask

    // Scoreboard monitor: every read-data pulse must match the oldest expectation.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rd_data_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got data %h want no read data", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(e));
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_empty", 64'(wbuf_empty), 64'(1));
        chk("rst_rvld",  64'(rd_data_vld), 64'(0));
        chk("rst_rdata", 64'(rd_data), 64'(0));
        chk("rst_cen",   64'(sram_cen), 64'(1));
        chk("rst_gwen",  64'(sram_gwen), 64'(1));
        chk("rst_wen",   64'(sram_wen), 64'(ALL1));
        chk("rst_a",     64'(sram_a), 64'(0));
        chk("rst_d",     64'(sram_d), 64'(0));

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_rrdy", 64'(rd_req_rdy), 64'(1));
        chk("idle_cen",  64'(sram_cen), 64'(1));

        // Full-mask write then read-back
        @(negedge clk);
        wr_set(8'h12, ALL1, ALL1);
        #1;
        chk("w12_wrdy", 64'(wr_req_rdy), 64'(1));
        chk("w12_cen",  64'(sram_cen), 64'(1));
        @(negedge clk);
        drive_idle();
        rd_req_vld  = 1'b1;
        rd_req_addr = 8'h12;
        #1;
        chk("w12_haz",  64'(rd_req_rdy), 64'(0));
        chk("w12_cen",  64'(sram_cen), 64'(0));
        chk("w12_gwen", 64'(sram_gwen), 64'(0));
        chk("w12_wen",  64'(sram_wen), 64'(0));
        chk("w12_a",    64'(sram_a), 64'(8'h12));
        chk("w12_d",    64'(sram_d), 64'(ALL1));
        @(negedge clk);
        rd_wait(8'h12, ALL1, "r12");

        // Low-byte masked write of zero over an all-ones word
        @(negedge clk);
        wr_set(8'h34, '0, 59'hFF);
        #1;
        chk("w34_wrdy", 64'(wr_req_rdy), 64'(1));
        @(negedge clk);
        drive_idle();
        #1;
        chk("w34_gwen", 64'(sram_gwen), 64'(0));
        chk("w34_wen",  64'(sram_wen), 64'(LOW0));
        chk("w34_a",    64'(sram_a), 64'(8'h34));
        @(negedge clk);
        rd_wait(8'h34, LOW0, "r34");

        // RAW hazard stall, then same-cycle read+write ordering
        @(negedge clk);
        wr_set(8'h05, D5A, ALL1);
        #1;
        chk("w05_wrdy", 64'(wr_req_rdy), 64'(1));
        @(negedge clk);
        drive_idle();
        rd_req_vld  = 1'b1;
        rd_req_addr = 8'h05;
        #1;
        chk("r05_haz",  64'(rd_req_rdy), 64'(0));
        chk("r05_dra",  64'(sram_a), 64'(8'h05));
        chk("r05_drg",  64'(sram_gwen), 64'(0));
        @(negedge clk);
        rd_wait(8'h05, D5A, "r05_new");
        @(negedge clk);
        rd_req_vld  = 1'b1;
        rd_req_addr = 8'h05;
        wr_set(8'h05, D5B, ALL1);
        #1;
        chk("rw05_rrdy", 64'(rd_req_rdy), 64'(1));
        chk("rw05_wrdy", 64'(wr_req_rdy), 64'(1));
        chk("rw05_gwen", 64'(sram_gwen), 64'(1));
        if (rd_req_rdy) exp_q.push_back(D5A);
        @(negedge clk);
        drive_idle();
        #1;
        chk("rw05_empty", 64'(wbuf_empty), 64'(0));
        chk("rw05_dra",   64'(sram_a), 64'(8'h05));
        chk("rw05_drd",   64'(sram_d), 64'(D5B));
        @(negedge clk);
        rd_wait(8'h05, D5B, "r05_b");

        // Starvation: fill under read pressure, 4 reads while full, one forced drain
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_idle();
            rd_req_vld  = 1'b1;
            rd_req_addr = 8'(8'h40 + i);
            if (i == 0) wr_set(8'h80, WA, ALL1);
            if (i == 1) wr_set(8'h81, WB, ALL1);
            #1;
            chk($sformatf("stv_rrdy%0d", i), 64'(rd_req_rdy), 64'((i == 6) ? 0 : 1));
            if (i == 2) chk("stv_full", 64'(wr_req_rdy), 64'(0));
            if (i == 6) begin
                chk("stv_dra",  64'(sram_a), 64'(8'h80));
                chk("stv_drg",  64'(sram_gwen), 64'(0));
            end
            if (rd_req_vld && rd_req_rdy) exp_q.push_back(pat(rd_req_addr));
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("stv_dr2a", 64'(sram_a), 64'(8'h81));
        chk("stv_dr2d", 64'(sram_d), 64'(WB));
        @(negedge clk);
        #1;
        chk("stv_empty", 64'(wbuf_empty), 64'(1));

        // Push into a full buffer on its drain cycle; order kept over 3 drains
        @(negedge clk);
        rd_req_vld  = 1'b1;
        rd_req_addr = 8'h50;
        wr_set(8'h90, W0, ALL1);
        #1;
        if (rd_req_rdy) exp_q.push_back(pat(8'h50));
        @(negedge clk);
        rd_req_addr = 8'h51;
        wr_set(8'h91, W1, ALL1);
        #1;
        chk("ord_w1rdy", 64'(wr_req_rdy), 64'(1));
        if (rd_req_rdy) exp_q.push_back(pat(8'h51));
        @(negedge clk);
        drive_idle();
        wr_set(8'h92, W2, ALL1);
        #1;
        chk("ord_w2rdy", 64'(wr_req_rdy), 64'(1));
        chk("ord_dr0a",  64'(sram_a), 64'(8'h90));
        chk("ord_dr0d",  64'(sram_d), 64'(W0));
        @(negedge clk);
        drive_idle();
        rd_req_vld  = 1'b1;
        rd_req_addr = 8'h55;
        #1;
        chk("ord_rrdy", 64'(rd_req_rdy), 64'(1));
        chk("ord_occ2", 64'(wr_req_rdy), 64'(0));
        if (rd_req_rdy) exp_q.push_back(pat(8'h55));
        @(negedge clk);
        drive_idle();
        #1;
        chk("ord_dr1a", 64'(sram_a), 64'(8'h91));
        chk("ord_dr1d", 64'(sram_d), 64'(W1));
        @(negedge clk);
        #1;
        chk("ord_dr2a", 64'(sram_a), 64'(8'h92));
        chk("ord_dr2d", 64'(sram_d), 64'(W2));
        @(negedge clk);
        #1;
        chk("ord_empty", 64'(wbuf_empty), 64'(1));
        chk("ord_cen",   64'(sram_cen), 64'(1));
        @(negedge clk);
        rd_wait(8'h90, W0, "rb90");
        @(negedge clk);
        rd_wait(8'h91, W1, "rb91");
        @(negedge clk);
        rd_wait(8'h92, W2, "rb92");
        @(negedge clk);
        rd_wait(8'h80, WA, "rb80");
        @(negedge clk);
        rd_wait(8'h81, WB, "rb81");

        // Asynchronous reset in the middle of a drain with a read in flight
        @(negedge clk);
        rd_req_vld  = 1'b1;
        rd_req_addr = 8'h60;
        wr_set(8'hA0, WA, ALL1);
        #1;
        chk("mrst_rrdy", 64'(rd_req_rdy), 64'(1));
        if (rd_req_rdy) exp_q.push_back(pat(8'h60));
        @(negedge clk);
        drive_idle();
        #1;
        chk("mrst_drcen", 64'(sram_cen), 64'(0));
        chk("mrst_drg",   64'(sram_gwen), 64'(0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_cen",   64'(sram_cen), 64'(1));
        chk("mrst_empty", 64'(wbuf_empty), 64'(1));
        chk("mrst_rvld",  64'(rd_data_vld), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_rrdy2", 64'(rd_req_rdy), 64'(1));
        @(negedge clk);
        rd_wait(8'hA0, pat(8'hA0), "rbA0");

        repeat (3) @(negedge clk);
        chk("sb_left", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
